// File: rtl/lfsr_multi.sv
// lfsr_multi: parametrised LFSR with runtime-selectable Fibonacci or Galois
// form, SHIFT steps per advance, zero-seed protection and on-line period
// measurement against the latched seed.
module lfsr_multi #(
  parameter int WIDTH      = 16,
  parameter int SHIFT      = 1,
  parameter int RESET_SEED = 1,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               reinit,
  input  logic               advance,
  input  logic               mode,
  input  logic [WIDTH-1:0]   seed,
  input  logic [WIDTH-1:0]   taps,
  output logic [SHIFT-1:0]   out,
  output logic [WIDTH-1:0]   out_state,
  output logic [CNT_W-1:0]   adv_count,
  output logic               period_hit,
  output logic [CNT_W-1:0]   period_len,
  output logic               period_valid,
  output logic               seed_fix
);

  localparam logic [WIDTH-1:0] SEED_DEF = WIDTH'(RESET_SEED);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // One Fibonacci step: feedback is the parity of the tapped bits.
  function automatic logic [WIDTH-1:0] fib_step(input logic [WIDTH-1:0] s,
                                                input logic [WIDTH-1:0] t);
    logic fb;
    fb = ^(s & t);
    return {s[WIDTH-2:0], fb};
  endfunction

  // One Galois step: shift left, fold the tap mask in when the MSB falls out.
  function automatic logic [WIDTH-1:0] gal_step(input logic [WIDTH-1:0] s,
                                                input logic [WIDTH-1:0] t);
    return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? t : {WIDTH{1'b0}});
  endfunction

  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] seed_lat_r;
  logic [CNT_W-1:0] adv_count_r;
  logic [CNT_W-1:0] period_len_r;
  logic             period_valid_r;
  logic             period_hit_r;
  logic             seed_fix_r;

  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] load_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             seed_zero_s;
  logic             match_s;

  // Chain SHIFT single steps and derive the load value, saturated count and seed match.
  always_comb begin
    next_s = state_r;
    for (int k = 0; k < SHIFT; k++) begin
      if (mode) begin
        next_s = gal_step(next_s, taps);
      end else begin
        next_s = fib_step(next_s, taps);
      end
    end
    seed_zero_s = (seed == {WIDTH{1'b0}});
    load_s      = seed_zero_s ? SEED_DEF : seed;
    if (adv_count_r == CNT_MAX) begin
      cnt_inc_s = adv_count_r;
    end else begin
      cnt_inc_s = adv_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    match_s = (next_s == seed_lat_r);
  end

  // State, counters and period measurement; reinit outranks advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= SEED_DEF;
      seed_lat_r     <= SEED_DEF;
      adv_count_r    <= {CNT_W{1'b0}};
      period_len_r   <= {CNT_W{1'b0}};
      period_valid_r <= 1'b0;
      period_hit_r   <= 1'b0;
      seed_fix_r     <= 1'b0;
    end else if (reinit) begin
      state_r        <= load_s;
      seed_lat_r     <= load_s;
      adv_count_r    <= {CNT_W{1'b0}};
      period_len_r   <= {CNT_W{1'b0}};
      period_valid_r <= 1'b0;
      period_hit_r   <= 1'b0;
      seed_fix_r     <= seed_zero_s;
    end else if (advance) begin
      state_r      <= next_s;
      adv_count_r  <= cnt_inc_s;
      period_hit_r <= match_s;
      seed_fix_r   <= 1'b0;
      if (match_s && !period_valid_r) begin
        period_len_r   <= cnt_inc_s;
        period_valid_r <= 1'b1;
      end else begin
        period_len_r   <= period_len_r;
        period_valid_r <= period_valid_r;
      end
    end else begin
      period_hit_r <= 1'b0;
      seed_fix_r   <= 1'b0;
    end
  end

  assign out          = state_r[SHIFT-1:0];
  assign out_state    = state_r;
  assign adv_count    = adv_count_r;
  assign period_hit   = period_hit_r;
  assign period_len   = period_len_r;
  assign period_valid = period_valid_r;
  assign seed_fix     = seed_fix_r;

endmodule

// File: tb/tb_lfsr_multi.sv
// tb_lfsr_multi: directed checks of lfsr_multi with 5-bit instances,
// one single-step and one double-step, using hand-computed expectations.
module tb_lfsr_multi;

  logic        clk;
  logic        rst_n;
  logic        reinit;
  logic        advance;
  logic        reinit2;
  logic        advance2;
  logic        mode;
  logic [4:0]  seed;
  logic [4:0]  taps;

  logic [0:0]  out1;
  logic [4:0]  st1;
  logic [31:0] cnt1;
  logic        hit1;
  logic [31:0] len1;
  logic        val1;
  logic        fix1;

  logic [1:0]  out2;
  logic [4:0]  st2;
  logic [31:0] cnt2;
  logic        hit2;
  logic [31:0] len2;
  logic        val2;
  logic        fix2;

  int checks = 0;
  int errors = 0;
  logic early_hit;

  lfsr_multi #(.WIDTH(5), .SHIFT(1), .RESET_SEED(1), .CNT_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .reinit(reinit), .advance(advance), .mode(mode),
    .seed(seed), .taps(taps), .out(out1), .out_state(st1), .adv_count(cnt1),
    .period_hit(hit1), .period_len(len1), .period_valid(val1), .seed_fix(fix1)
  );

  lfsr_multi #(.WIDTH(5), .SHIFT(2), .RESET_SEED(1), .CNT_W(32)) u2 (
    .clk(clk), .rst_n(rst_n), .reinit(reinit2), .advance(advance2), .mode(mode),
    .seed(seed), .taps(taps), .out(out2), .out_state(st2), .adv_count(cnt2),
    .period_hit(hit2), .period_len(len2), .period_valid(val2), .seed_fix(fix2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; reinit = 1'b0; advance = 1'b0; reinit2 = 1'b0; advance2 = 1'b0;
    mode = 1'b0; seed = 5'b00000; taps = 5'b00000;
    early_hit = 1'b0;
    cyc(); cyc();
    chk("rst_state", 32'(st1), 32'h1);
    chk("rst_cnt", cnt1, 32'h0);
    chk("rst_valid", 32'(val1), 32'h0);
    chk("rst_len", len1, 32'h0);
    chk("rst_hit", 32'(hit1), 32'h0);
    chk("rst_fix", 32'(fix1), 32'h0);
    rst_n = 1'b1;
    cyc();

    // Test 1: Fibonacci, taps 10100, seed 00001, three advances
    mode = 1'b0; taps = 5'b10100; seed = 5'b00001;
    reinit = 1'b1; cyc(); reinit = 1'b0;
    chk("t1_seed_fix", 32'(fix1), 32'h0);
    advance = 1'b1;
    cyc(); chk("t1_s1", 32'(st1), 32'h02); chk("t1_o1", 32'(out1), 32'h0);
    cyc(); chk("t1_s2", 32'(st1), 32'h04); chk("t1_o2", 32'(out1), 32'h0);
    cyc(); chk("t1_s3", 32'(st1), 32'h09); chk("t1_o3", 32'(out1), 32'h1);
    chk("t1_cnt", cnt1, 32'd3);

    // Test 2: continue to advance 31, then 31 more
    for (int i = 0; i < 28; i++) begin
      cyc();
      if (i < 27 && hit1) early_hit = 1'b1;
    end
    advance = 1'b0;
    chk("t2_no_early_hit", 32'(early_hit), 32'h0);
    chk("t2_hit", 32'(hit1), 32'h1);
    chk("t2_state", 32'(st1), 32'h01);
    chk("t2_len", len1, 32'd31);
    chk("t2_valid", 32'(val1), 32'h1);
    cyc();
    chk("t2_hit_pulse", 32'(hit1), 32'h0);
    advance = 1'b1;
    repeat (31) cyc();
    advance = 1'b0;
    chk("t2_hit2", 32'(hit1), 32'h1);
    chk("t2_len_keep", len1, 32'd31);
    chk("t2_cnt62", cnt1, 32'd62);

    // Test 3: Galois, taps 00101, seed 10000
    mode = 1'b1; taps = 5'b00101; seed = 5'b10000;
    reinit = 1'b1; cyc(); reinit = 1'b0;
    chk("t3_reinit_cnt", cnt1, 32'h0);
    chk("t3_reinit_valid", 32'(val1), 32'h0);
    advance = 1'b1;
    cyc(); chk("t3_s1", 32'(st1), 32'h05);
    cyc(); chk("t3_s2", 32'(st1), 32'h0A);
    advance = 1'b0;

    // Test 4: SHIFT=2 instance, Fibonacci taps 10100, seed 00001
    mode = 1'b0; taps = 5'b10100; seed = 5'b00001;
    reinit2 = 1'b1; cyc(); reinit2 = 1'b0;
    advance2 = 1'b1;
    cyc(); chk("t4_s1", 32'(st2), 32'h04); chk("t4_o1", 32'(out2), 32'h0);
    cyc(); chk("t4_s2", 32'(st2), 32'h12); chk("t4_o2", 32'(out2), 32'h2);
    chk("t4_cnt", cnt2, 32'd2);
    advance2 = 1'b0;

    // Test 5: zero seed replaced, then reinit with advance together
    seed = 5'b00000;
    reinit = 1'b1; cyc(); reinit = 1'b0;
    chk("t5_state", 32'(st1), 32'h01);
    chk("t5_fix", 32'(fix1), 32'h1);
    cyc();
    chk("t5_fix_pulse", 32'(fix1), 32'h0);
    seed = 5'b00110; reinit = 1'b1; advance = 1'b1;
    cyc();
    reinit = 1'b0; advance = 1'b0;
    chk("t5_ra_state", 32'(st1), 32'h06);
    chk("t5_ra_cnt", cnt1, 32'h0);

    // Test 6: rotation taps give period 5, run to count 7, then async reset
    taps = 5'b10000; seed = 5'b00001; mode = 1'b0;
    reinit = 1'b1; cyc(); reinit = 1'b0;
    advance = 1'b1;
    repeat (7) cyc();
    advance = 1'b0;
    chk("t6_cnt7", cnt1, 32'd7);
    chk("t6_valid", 32'(val1), 32'h1);
    chk("t6_len5", len1, 32'd5);
    chk("t6_state", 32'(st1), 32'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_state", 32'(st1), 32'h01);
    chk("t6_async_cnt", cnt1, 32'h0);
    chk("t6_async_valid", 32'(val1), 32'h0);
    chk("t6_async_len", len1, 32'h0);
    chk("t6_async_hit", 32'(hit1), 32'h0);
    cyc();
    rst_n = 1'b1;
    taps = 5'b10100;
    advance = 1'b1;
    cyc();
    advance = 1'b0;
    chk("t6_restart", 32'(st1), 32'h02);
    chk("t6_restart_cnt", cnt1, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_multi.md
Name: lfsr_multi

Overview:
- Parametrised successor to the team's fixed 5-bit LFSR.
- Generalises to WIDTH bits, SHIFT steps per advance, and runtime-selectable Fibonacci or Galois form.
- Adds zero-seed protection and an on-line period measurement.
- Used as a scrambler and test-pattern source beside datapath blocks; software programs taps and seed.

Parameters:
WIDTH, 16, state width in bits (>=3)
SHIFT, 1, LFSR steps applied per advance cycle (1..WIDTH)
RESET_SEED, 1, state loaded on reset and used in place of an all-zero seed (must be nonzero)
CNT_W, 32, width of advance and period counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
reinit  in  1  load seed into state this cycle
advance  in  1  apply SHIFT steps this cycle
mode  in  1  0 = Fibonacci, 1 = Galois; sampled when advance is high
seed  in  WIDTH  seed value, sampled on reinit
taps  in  WIDTH  tap mask, sampled on every advance
out  out  SHIFT  state[SHIFT-1:0]; bit 0 is the newest bit
out_state  out  WIDTH  current state register
adv_count  out  CNT_W  advances since last reinit/reset, saturating
period_hit  out  1  one-cycle pulse: state just returned to latched seed
period_len  out  CNT_W  adv_count value at first period_hit since reinit
period_valid  out  1  period_len holds a measured value
seed_fix  out  1  one-cycle pulse: zero seed replaced by RESET_SEED

Behaviour:
- rst_n low (async): state=RESET_SEED, seed_lat=RESET_SEED, adv_count=0, period_len=0, period_valid=0, period_hit=0, seed_fix=0. Deassertion is synchronous to clk (external synchroniser).
- Priority per cycle: reinit > advance > hold.
- reinit:
  - state and seed_lat <= (seed==0 ? RESET_SEED : seed).
  - seed_fix <= (seed==0).
  - adv_count, period_len, period_valid <= 0; period_hit <= 0.
  - An advance asserted in the same cycle is ignored.
- Fibonacci single step: fb = XOR over i of (taps[i] & s[i]); s' = {s[WIDTH-2:0], fb}.
- Galois single step: s' = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? taps : 0).
- advance (no reinit): state <= SHIFT single steps chained combinationally in one cycle; result identical to SHIFT consecutive single-step advances.
- adv_count <= adv_count+1 on each advance; saturates at all-ones and never wraps.
- period_hit (registered) = 1 in the cycle after an advance whose next state equals seed_lat; 0 otherwise.
- On that advance, if period_valid==0: period_len <= adv_count+1 (saturated), period_valid <= 1. Later hits pulse period_hit but do not change period_len.
- With SHIFT>1, only states at advance boundaries are compared; intermediate steps are not.
- All-zero state: only reachable via taps/mode reprogramming. It holds at zero under Fibonacci and Galois steps. No auto-recovery; software reinits.
- Changing taps or mode mid-sequence is legal and takes effect on the next advance. Period measurement is not re-armed by this.
- out and out_state are combinational from the state register (zero latency after the clock edge).
- rst_n asserted mid-operation overrides everything immediately; all outputs go to reset values within the same cycle.

Test Plan:
1. WIDTH=5, SHIFT=1, mode=0, taps=5'b10100, reinit seed=5'b00001, then 3 advances -> out_state 00010, 00100, 01001; out=0,0,1; adv_count=3.
2. Same config, continuous advance -> period_hit pulses after advance 31 with state=00001; period_len=31, period_valid=1. Advance 31 more -> period_hit pulses again; period_len stays 31.
3. WIDTH=5, SHIFT=1, mode=1, taps=5'b00101, seed=5'b10000, 2 advances -> out_state 00101 then 01010.
4. WIDTH=5, SHIFT=2, mode=0, taps=5'b10100, seed=00001 -> first advance gives 00100, out=2'b00; second advance gives 10010, out=2'b10.
5. Zero seed: reinit with seed=0 -> out_state=RESET_SEED, seed_fix high for exactly one cycle. reinit and advance together -> state=seed, adv_count=0.
6. rst_n pulsed low mid-run (adv_count=7, period_valid=1) -> all outputs reset asynchronously with no clock edge needed; sequence restarts from RESET_SEED.
